// File: rtl/ascii_pkg.sv
// ascii_pkg: shared text-grid constants, write-request type and on-screen address test
package ascii_pkg;
  localparam int COLS = 80;
  localparam int ROWS = 60;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int MAX_ADDR = COLS * ROWS - 1;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ascii_wr_t;
  function automatic logic is_onscreen(input logic [ADDR_W-1:0] addr);
    return addr <= ADDR_W'(MAX_ADDR);
  endfunction
endpackage

// File: rtl/ascii_wq_mem.sv
// ascii_wq_mem: write-request storage, synchronous write, asynchronous read, not reset
module ascii_wq_mem
  import ascii_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  ascii_wr_t                wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output ascii_wr_t                rdata
);
  ascii_wr_t mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/ascii_write_queue.sv
// ascii_write_queue: show-ahead write FIFO for the character memory; ASCII_WQ_COALESCE_EN merges repeat writes to the newest entry
module ascii_write_queue
  import ascii_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic                       bad_addr,
  input  logic                       flag_clr
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  logic [PW-1:0] wr_ptr, rd_ptr, wr_addr;
  logic full, push, pop, store, coal, match, onscreen;
  ascii_wr_t head;
`ifdef ASCII_WQ_COALESCE_EN
  logic [ADDR_W-1:0] last_addr;
`endif
  always_comb begin
    onscreen = is_onscreen(in_addr);
    full = level == LW'(DEPTH);
    out_valid = level != '0;
    pop = out_valid & out_ready;
`ifdef ASCII_WQ_COALESCE_EN
    match = out_valid && last_addr == in_addr && !(level == LW'(1) && pop);
`else
    match = 1'b0;
`endif
    in_ready = !full || match;
    push = in_valid & in_ready;
    coal = push & match & onscreen;
    store = push & onscreen & !coal;
    wr_addr = coal ? wr_ptr - PW'(1) : wr_ptr;
    out_addr = out_valid ? head.addr : '0;
    out_data = out_valid ? head.data : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      overflow <= 1'b0;
      bad_addr <= 1'b0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      level <= level + LW'(store) - LW'(pop);
      overflow <= (in_valid & !in_ready) | (overflow & !flag_clr);
      bad_addr <= (push & !onscreen) | (bad_addr & !flag_clr);
    end
  end
`ifdef ASCII_WQ_COALESCE_EN
  // Newest stored address; only meaningful while the queue is non-empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_addr <= '0;
    else if (store) last_addr <= in_addr;
  end
`endif
  ascii_wq_mem #(.DEPTH(DEPTH)) u_mem (
    .clk  (clk),
    .we   (store | coal),
    .waddr(wr_addr),
    .wdata(ascii_wr_t'{addr: in_addr, data: in_data}),
    .raddr(rd_ptr),
    .rdata(head)
  );
endmodule

// File: tb/tb_ascii_write_queue.sv
// tb_ascii_write_queue: directed self-checking bench for ascii_write_queue
module tb_ascii_write_queue;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, overflow, bad_addr, flag_clr = 0;
  logic [12:0] in_addr = '0, out_addr;
  logic [31:0] in_data = '0, out_data;
  logic [4:0] level;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ascii_write_queue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .level(level), .overflow(overflow), .bad_addr(bad_addr), .flag_clr(flag_clr)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [12:0] a, input logic [31:0] d);
    in_valid = 1; in_addr = a; in_data = d;
    step();
    in_valid = 0;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 5; i++) push(13'(10 + i), 32'h5500_0000 + i);
    push(13'd4800, 32'h0);
    checks++; if (level !== 5'd5) begin errors++; $display("FAIL reset_pre_level got %0d exp 5", level); end
    checks++; if (bad_addr !== 1'b1) begin errors++; $display("FAIL reset_pre_bad got %b exp 1", bad_addr); end
    #2 rst = 1;
    #1;
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (overflow !== 1'b0 || bad_addr !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", overflow, bad_addr); end
    step();
    rst = 0;
    step();
  endtask
  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) push(13'(i), 32'hA000_0000 + i);
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL fill_level got %0d exp 16", level); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %b exp 0", in_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow_early got %b exp 0", overflow); end
    push(13'd99, 32'hDEAD_BEEF);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set got %b exp 1", overflow); end
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL overflow_level got %0d exp 16", level); end
    out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_addr !== 13'(i) || out_data !== 32'hA000_0000 + i) begin
        errors++; $display("FAIL drain_%0d got v=%b a=%0d d=%h exp v=1 a=%0d d=%h", i, out_valid, out_addr, out_data, i, 32'hA000_0000 + i);
      end
      step();
    end
    out_ready = 0;
    checks++; if (level !== 5'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got l=%0d v=%b exp 0 0", level, out_valid); end
    checks++; if (out_addr !== 13'd0 || out_data !== 32'd0) begin errors++; $display("FAIL empty_mask got a=%0d d=%h exp 0 0", out_addr, out_data); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got %b exp 1", overflow); end
    flag_clr = 1; step(); flag_clr = 0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clr got %b exp 0", overflow); end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) push(13'(200 + i), 32'hB000_0000 + 200 + i);
    out_ready = 1; in_valid = 1;
    for (int k = 0; k < 40; k++) begin
      in_addr = 13'(208 + k); in_data = 32'hB000_0000 + 208 + k;
      checks++;
      if (out_addr !== 13'(200 + k) || out_data !== 32'hB000_0000 + 200 + k) begin
        errors++; $display("FAIL b2b_head_%0d got a=%0d d=%h exp a=%0d", k, out_addr, out_data, 200 + k);
      end
      step();
      checks++; if (level !== 5'd8) begin errors++; $display("FAIL b2b_level_%0d got %0d exp 8", k, level); end
    end
    in_valid = 0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_addr !== 13'(240 + i) || out_data !== 32'hB000_0000 + 240 + i) begin
        errors++; $display("FAIL b2b_tail_%0d got a=%0d d=%h exp a=%0d", i, out_addr, out_data, 240 + i);
      end
      step();
    end
    out_ready = 0;
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL b2b_end_level got %0d exp 0", level); end
  endtask
  task automatic test_bad_addr();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bad_ready got %b exp 1", in_ready); end
    push(13'd4800, 32'h4100_00FF);
    checks++; if (level !== 5'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL bad_not_stored got l=%0d v=%b exp 0 0", level, out_valid); end
    checks++; if (bad_addr !== 1'b1) begin errors++; $display("FAIL bad_set got %b exp 1", bad_addr); end
    flag_clr = 1; step(); flag_clr = 0;
    checks++; if (bad_addr !== 1'b0) begin errors++; $display("FAIL bad_clr got %b exp 0", bad_addr); end
    push(13'd4799, 32'h5A12_3456);
    checks++; if (level !== 5'd1 || out_addr !== 13'd4799 || out_data !== 32'h5A12_3456) begin
      errors++; $display("FAIL max_addr got l=%0d a=%0d d=%h exp 1 4799 5a123456", level, out_addr, out_data);
    end
    checks++; if (bad_addr !== 1'b0) begin errors++; $display("FAIL max_addr_flag got %b exp 0", bad_addr); end
    flag_clr = 1; in_valid = 1; in_addr = 13'd8191; step(); flag_clr = 0; in_valid = 0;
    checks++; if (bad_addr !== 1'b1) begin errors++; $display("FAIL set_wins got %b exp 1", bad_addr); end
    flag_clr = 1; out_ready = 1; step(); flag_clr = 0; out_ready = 0;
    checks++; if (level !== 5'd0 || bad_addr !== 1'b0) begin errors++; $display("FAIL bad_end got l=%0d b=%b exp 0 0", level, bad_addr); end
  endtask
  task automatic test_coalesce();
    push(13'd100, 32'h4100_0001);
    push(13'd100, 32'h4200_0002);
`ifdef ASCII_WQ_COALESCE_EN
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL coal_level got %0d exp 1", level); end
    checks++; if (out_data[31:24] !== 8'h42) begin errors++; $display("FAIL coal_head got %h exp 42", out_data[31:24]); end
    out_ready = 1; step(); out_ready = 0;
`else
    checks++; if (level !== 5'd2) begin errors++; $display("FAIL coal_level got %0d exp 2", level); end
    checks++; if (out_data[31:24] !== 8'h41) begin errors++; $display("FAIL coal_head0 got %h exp 41", out_data[31:24]); end
    out_ready = 1; step();
    checks++; if (out_data[31:24] !== 8'h42) begin errors++; $display("FAIL coal_head1 got %h exp 42", out_data[31:24]); end
    step(); out_ready = 0;
`endif
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL coal_end got %0d exp 0", level); end
  endtask
  task automatic test_empty_push();
    out_ready = 1; in_valid = 1; in_addr = 13'd300; in_data = 32'h4300_0300;
    step();
    in_valid = 0;
    checks++; if (level !== 5'd1 || out_valid !== 1'b1) begin errors++; $display("FAIL empty_push got l=%0d v=%b exp 1 1", level, out_valid); end
    checks++; if (out_addr !== 13'd300 || out_data !== 32'h4300_0300) begin errors++; $display("FAIL empty_push_head got a=%0d d=%h exp 300 43000300", out_addr, out_data); end
    step();
    out_ready = 0;
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL empty_push_pop got %0d exp 0", level); end
  endtask
  initial begin
    step(); step();
    rst = 0;
    step();
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_bad_addr();
    test_coalesce();
    test_empty_push();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
